// File: rtl/adc_conv_sequencer.sv
// ADC conversion sequencer: issues adc_start pulses, averages 2^N samples,
// writes results to the output FIFO and tracks drops and conversion timeouts.
module adc_conv_sequencer #(
  parameter int DATA_W         = 8,
  parameter int AVG_MAX_LOG2   = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              cfg_enable,
  input  logic              cfg_continuous,
  input  logic [31:0]       cfg_interval,
  input  logic [2:0]        cfg_avg_log2,
  input  logic              trigger,
  input  logic              clear_err,
  output logic              adc_start,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_value,
  output logic [DATA_W-1:0] fifo_data,
  output logic              fifo_wr,
  input  logic              fifo_full,
  output logic              seq_busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int ACC_W = DATA_W + AVG_MAX_LOG2;
  localparam int SC_W  = AVG_MAX_LOG2 + 1;
  localparam int NW    = (AVG_MAX_LOG2 < 1) ? 1 : $clog2(AVG_MAX_LOG2 + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_VALID, EMIT, INTERVAL} state_t;

  state_t          state;
  logic [NW-1:0]   n_lat;
  logic [ACC_W-1:0] acc;
  logic [SC_W-1:0] sample_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [31:0]     int_cnt;

  logic [NW-1:0]     n_sel;
  logic [ACC_W-1:0]  acc_sum;
  logic [SC_W-1:0]   cnt_inc;
  logic [SC_W-1:0]   target;
  logic [DATA_W-1:0] result;
  logic [CNT_W-1:0]  drop_base;
  logic [CNT_W-1:0]  drop_sat;

  // Datapath helpers: clamped exponent, running sum, result and saturating drop count
  always_comb begin
    n_sel     = '0;
    drop_base = '0;
    if (32'(cfg_avg_log2) > AVG_MAX_LOG2) begin
      n_sel = NW'(AVG_MAX_LOG2);
    end else begin
      n_sel = NW'(cfg_avg_log2);
    end
    acc_sum = acc + ACC_W'(adc_value);
    cnt_inc = sample_cnt + SC_W'(1);
    target  = SC_W'(1) << n_lat;
    result  = DATA_W'(acc >> n_lat);
    // a clear coinciding with a drop restarts the count at one
    if (clear_err) begin
      drop_base = '0;
    end else begin
      drop_base = drop_count;
    end
    if (drop_base == {CNT_W{1'b1}}) begin
      drop_sat = drop_base;
    end else begin
      drop_sat = drop_base + CNT_W'(1);
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (res) begin
      state       <= IDLE;
      n_lat       <= '0;
      acc         <= '0;
      sample_cnt  <= '0;
      to_cnt      <= '0;
      int_cnt     <= 32'd0;
      adc_start   <= 1'b0;
      fifo_wr     <= 1'b0;
      fifo_data   <= '0;
      seq_busy    <= 1'b0;
      timeout_err <= 1'b0;
      drop_count  <= '0;
    end else begin
      adc_start <= 1'b0;
      fifo_wr   <= 1'b0;
      if (clear_err) begin
        timeout_err <= 1'b0;
        drop_count  <= '0;
      end
      case (state)
        IDLE: begin
          if (cfg_enable && (cfg_continuous || trigger)) begin
            state      <= START;
            n_lat      <= n_sel;
            acc        <= '0;
            sample_cnt <= '0;
            adc_start  <= 1'b1;
            seq_busy   <= 1'b1;
          end
        end
        START: begin
          state  <= WAIT_VALID;
          to_cnt <= '0;
        end
        WAIT_VALID: begin
          // a sample arriving on the last timeout cycle still counts
          if (adc_valid) begin
            acc        <= acc_sum;
            sample_cnt <= cnt_inc;
            if (cnt_inc == target) begin
              state <= EMIT;
            end else if (!cfg_enable) begin
              state    <= IDLE;
              seq_busy <= 1'b0;
            end else begin
              state     <= START;
              adc_start <= 1'b1;
            end
          end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            seq_busy    <= 1'b0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        EMIT: begin
          if (!fifo_full) begin
            fifo_data <= result;
            fifo_wr   <= 1'b1;
          end else begin
            drop_count <= drop_sat;
          end
          if (cfg_continuous && cfg_enable) begin
            state   <= INTERVAL;
            int_cnt <= 32'd0;
          end else begin
            state    <= IDLE;
            seq_busy <= 1'b0;
          end
        end
        INTERVAL: begin
          if (!cfg_enable || (int_cnt == cfg_interval)) begin
            state    <= IDLE;
            seq_busy <= 1'b0;
          end else begin
            int_cnt <= int_cnt + 32'd1;
          end
        end
        default: begin
          state    <= IDLE;
          seq_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed self-checking bench for adc_conv_sequencer with a behavioural ADC
// that answers each adc_start with the next queued sample five cycles later.
module tb_adc_conv_sequencer;

  localparam int DATA_W  = 8;
  localparam int CW      = 2;
  localparam int ADC_DLY = 5;

  logic              clk = 1'b0;
  logic              res = 1'b1;
  logic              cfg_enable = 1'b0;
  logic              cfg_continuous = 1'b0;
  logic [31:0]       cfg_interval = 32'd0;
  logic [2:0]        cfg_avg_log2 = 3'd0;
  logic              trigger = 1'b0;
  logic              clear_err = 1'b0;
  logic              adc_start;
  logic              adc_valid = 1'b0;
  logic [DATA_W-1:0] adc_value = 8'h00;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_wr;
  logic              fifo_full = 1'b0;
  logic              seq_busy;
  logic              timeout_err;
  logic [CW-1:0]     drop_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0, n_start = 0, n_wr = 0, t_start = 0, t_wr = 0, start_gap = 0, wr_gap = 0;
  logic [7:0] last_data = 8'h00;
  bit adc_mute = 1'b0;
  int pend = -1;
  logic [7:0] sq[$];

  adc_conv_sequencer #(.DATA_W(DATA_W), .AVG_MAX_LOG2(4), .TIMEOUT_CYCLES(16), .CNT_W(CW)) dut (
    .clk(clk), .res(res), .cfg_enable(cfg_enable), .cfg_continuous(cfg_continuous),
    .cfg_interval(cfg_interval), .cfg_avg_log2(cfg_avg_log2), .trigger(trigger),
    .clear_err(clear_err), .adc_start(adc_start), .adc_valid(adc_valid),
    .adc_value(adc_value), .fifo_data(fifo_data), .fifo_wr(fifo_wr),
    .fifo_full(fifo_full), .seq_busy(seq_busy), .timeout_err(timeout_err),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Observe strobes just after each rising edge
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (adc_start) begin
      n_start++;
      start_gap = cyc - t_start;
      wr_gap    = cyc - t_wr;
      t_start   = cyc;
    end
    if (fifo_wr) begin
      n_wr++;
      t_wr      = cyc;
      last_data = fifo_data;
    end
  end

  // ADC model
  initial forever begin
    @(negedge clk);
    adc_valid = 1'b0;
    if (pend == 0) begin
      adc_valid = 1'b1;
      if (sq.size() > 0) adc_value = sq.pop_front();
      else adc_value = 8'h00;
      pend = -1;
    end else if (pend > 0) begin
      pend--;
    end
    if (adc_start && !adc_mute) pend = ADC_DLY - 1;
  end

  task automatic pulse_trigger();
    @(negedge clk); trigger = 1'b1;
    @(negedge clk); trigger = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!seq_busy) break;
      @(negedge clk);
    end
    checks++;
    if (i == budget) begin errors++; $display("FAIL %s_idle_timeout: busy=%0b required 0", tag, seq_busy); end
  endtask

  task automatic wait_starts(input int target, input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      if (n_start >= target) break;
      @(negedge clk);
    end
    checks++;
    if (i == budget) begin errors++; $display("FAIL %s_start_timeout: starts=%0d required %0d", tag, n_start, target); end
  endtask

  task automatic wait_wrs(input int target, input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      if (n_wr >= target) break;
      @(negedge clk);
    end
    checks++;
    if (i == budget) begin errors++; $display("FAIL %s_wr_timeout: writes=%0d required %0d", tag, n_wr, target); end
  endtask

  task automatic test_reset();
    res = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (adc_start !== 1'b0) begin errors++; $display("FAIL rst_adc_start: got %0b required 0", adc_start); end
    checks++; if (fifo_wr !== 1'b0) begin errors++; $display("FAIL rst_fifo_wr: got %0b required 0", fifo_wr); end
    checks++; if (fifo_data !== 8'h00) begin errors++; $display("FAIL rst_fifo_data: got %0h required 0", fifo_data); end
    checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL rst_seq_busy: got %0b required 0", seq_busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %0b required 0", timeout_err); end
    checks++; if (drop_count !== 2'd0) begin errors++; $display("FAIL rst_drop_count: got %0d required 0", drop_count); end
    res = 1'b0;
  endtask

  task automatic test_single();
    int s0, w0;
    cfg_enable = 1'b1; cfg_continuous = 1'b0; cfg_avg_log2 = 3'd0;
    sq.push_back(8'hA5);
    s0 = n_start; w0 = n_wr;
    pulse_trigger();
    wait_idle(40, "single");
    repeat (3) @(negedge clk);
    checks++; if (n_start - s0 !== 1) begin errors++; $display("FAIL single_starts: got %0d required 1", n_start - s0); end
    checks++; if (n_wr - w0 !== 1) begin errors++; $display("FAIL single_writes: got %0d required 1", n_wr - w0); end
    checks++; if (last_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h required a5", last_data); end
    checks++; if (fifo_data !== 8'hA5) begin errors++; $display("FAIL single_hold: got %0h required a5", fifo_data); end
    checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %0b required 0", seq_busy); end
  endtask

  task automatic test_average();
    int s0, w0;
    cfg_avg_log2 = 3'd2;
    sq.push_back(8'h10); sq.push_back(8'h11); sq.push_back(8'h12); sq.push_back(8'h14);
    s0 = n_start; w0 = n_wr;
    pulse_trigger();
    repeat (3) @(negedge clk);
    pulse_trigger();
    wait_idle(100, "avg1");
    repeat (3) @(negedge clk);
    checks++; if (n_start - s0 !== 4) begin errors++; $display("FAIL avg_starts: got %0d required 4", n_start - s0); end
    checks++; if (n_wr - w0 !== 1) begin errors++; $display("FAIL avg_writes: got %0d required 1", n_wr - w0); end
    checks++; if (last_data !== 8'h11) begin errors++; $display("FAIL avg_data: got %0h required 11", last_data); end
    repeat (4) sq.push_back(8'hFF);
    s0 = n_start;
    pulse_trigger();
    wait_idle(100, "avg2");
    repeat (3) @(negedge clk);
    checks++; if (n_start - s0 !== 4) begin errors++; $display("FAIL avg_ff_starts: got %0d required 4", n_start - s0); end
    checks++; if (last_data !== 8'hFF) begin errors++; $display("FAIL avg_ff_data: got %0h required ff", last_data); end
  endtask

  task automatic test_continuous();
    int s, w;
    cfg_avg_log2 = 3'd0; cfg_interval = 32'd0;
    for (int i = 0; i < 12; i++) sq.push_back(8'(i + 1));
    @(negedge clk);
    cfg_continuous = 1'b1;
    s = n_start;
    wait_starts(s + 3, 100, "cont0");
    checks++; if (start_gap !== 9) begin errors++; $display("FAIL cont_start_gap: got %0d required 9", start_gap); end
    cfg_interval = 32'd10;
    for (int k = 0; k < 2; k++) begin
      w = n_wr;
      wait_wrs(w + 2, 100, "cont10");
      s = n_start;
      wait_starts(s + 1, 40, "cont10");
      checks++; if (wr_gap !== 12) begin errors++; $display("FAIL cont_wr_gap: got %0d required 12", wr_gap); end
    end
    w = n_wr;
    wait_wrs(w + 1, 60, "cont_stop");
    cfg_enable = 1'b0;
    s = n_start;
    repeat (30) @(negedge clk);
    checks++; if (n_start !== s) begin errors++; $display("FAIL cont_stop_starts: got %0d required %0d", n_start, s); end
    checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL cont_stop_busy: got %0b required 0", seq_busy); end
    cfg_continuous = 1'b0; cfg_enable = 1'b1;
    sq.delete();
  endtask

  task automatic test_fifo_full();
    int w0;
    fifo_full = 1'b1; w0 = n_wr;
    for (int i = 0; i < 3; i++) begin pulse_trigger(); wait_idle(40, "full3"); end
    @(negedge clk);
    checks++; if (drop_count !== 2'd3) begin errors++; $display("FAIL drop3: got %0d required 3", drop_count); end
    checks++; if (n_wr !== w0) begin errors++; $display("FAIL drop_no_write: got %0d required %0d", n_wr, w0); end
    pulse_clear();
    checks++; if (drop_count !== 2'd0) begin errors++; $display("FAIL drop_clear: got %0d required 0", drop_count); end
    for (int i = 0; i < 5; i++) begin pulse_trigger(); wait_idle(40, "full5"); end
    @(negedge clk);
    checks++; if (drop_count !== 2'd3) begin errors++; $display("FAIL drop_sat: got %0d required 3", drop_count); end
    // clear lands in the EMIT cycle: increment from zero wins
    @(negedge clk); trigger = 1'b1;
    @(negedge clk); trigger = 1'b0;
    repeat (6) @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
    checks++; if (drop_count !== 2'd1) begin errors++; $display("FAIL drop_clear_coincide: got %0d required 1", drop_count); end
    wait_idle(40, "full_co");
    fifo_full = 1'b0;
    pulse_clear();
  endtask

  task automatic test_timeout();
    int w0;
    adc_mute = 1'b1; w0 = n_wr;
    @(negedge clk); trigger = 1'b1;
    @(negedge clk); trigger = 1'b0;
    repeat (16) @(negedge clk);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early: got %0b required 0", timeout_err); end
    checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL to_busy_wait: got %0b required 1", seq_busy); end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_set: got %0b required 1", timeout_err); end
    checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL to_idle: got %0b required 0", seq_busy); end
    checks++; if (n_wr !== w0) begin errors++; $display("FAIL to_no_write: got %0d required %0d", n_wr, w0); end
    pulse_clear();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %0b required 0", timeout_err); end
    @(negedge clk); trigger = 1'b1;
    @(negedge clk); trigger = 1'b0;
    repeat (16) @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_clear_coincide: got %0b required 1", timeout_err); end
    pulse_clear();
    adc_mute = 1'b0;
    sq.push_back(8'h3C); w0 = n_wr;
    pulse_trigger();
    wait_idle(40, "to_after");
    @(negedge clk);
    checks++; if (n_wr - w0 !== 1) begin errors++; $display("FAIL to_after_writes: got %0d required 1", n_wr - w0); end
    checks++; if (last_data !== 8'h3C) begin errors++; $display("FAIL to_after_data: got %0h required 3c", last_data); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_after_flag: got %0b required 0", timeout_err); end
  endtask

  task automatic test_reset_mid();
    int s0, w0;
    cfg_avg_log2 = 3'd3;
    repeat (8) sq.push_back(8'h77);
    s0 = n_start;
    pulse_trigger();
    wait_starts(s0 + 3, 60, "rmid");
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    checks++; if (adc_start !== 1'b0) begin errors++; $display("FAIL rmid_adc_start: got %0b required 0", adc_start); end
    checks++; if (fifo_wr !== 1'b0) begin errors++; $display("FAIL rmid_fifo_wr: got %0b required 0", fifo_wr); end
    checks++; if (fifo_data !== 8'h00) begin errors++; $display("FAIL rmid_fifo_data: got %0h required 0", fifo_data); end
    checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b required 0", seq_busy); end
    repeat (8) @(negedge clk);
    sq.delete();
    for (int i = 0; i < 8; i++) sq.push_back(8'(8'h20 + i));
    s0 = n_start; w0 = n_wr;
    pulse_trigger();
    wait_idle(200, "rmid2");
    @(negedge clk);
    checks++; if (n_start - s0 !== 8) begin errors++; $display("FAIL rmid_starts: got %0d required 8", n_start - s0); end
    checks++; if (n_wr - w0 !== 1) begin errors++; $display("FAIL rmid_writes: got %0d required 1", n_wr - w0); end
    checks++; if (last_data !== 8'h23) begin errors++; $display("FAIL rmid_data: got %0h required 23", last_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_average();
    test_continuous();
    test_fifo_full();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_conv_sequencer.md
Name: adc_conv_sequencer

Overview:
Conversion sequencer in the ADC (divided) clock domain, between the synchronised SPI control bits and adc_system_top.
- Issues adc_start pulses, either single-shot or free-running at a programmable interval.
- Averages 2^N consecutive samples into one result.
- Pushes results into the ADC output FIFO write port, counts drops on FIFO full, and flags conversion timeouts.

Parameters:
DATA_W, 8, ADC sample width
AVG_MAX_LOG2, 4, maximum averaging exponent; accumulator width DATA_W+AVG_MAX_LOG2
TIMEOUT_CYCLES, 4096, cycles allowed from adc_start to adc_valid before abort
CNT_W, 16, width of the drop counter

Ports:
clk  in  1  ADC domain clock (divided clock)
res  in  1  synchronous reset, active-high
cfg_enable  in  1  sequencer enable level (already synchronised)
cfg_continuous  in  1  1 = free-running, 0 = single-shot per trigger
cfg_interval  in  32  idle cycles between a result and the next adc_start
cfg_avg_log2  in  3  averaging exponent N (samples per result = 2^N)
trigger  in  1  single-shot request pulse
clear_err  in  1  pulse; clears timeout_err and drop_count
adc_start  out  1  one-cycle conversion start to ADC
adc_valid  in  1  one-cycle sample-valid from ADC
adc_value  in  DATA_W  sample, qualified by adc_valid
fifo_data  out  DATA_W  averaged result
fifo_wr  out  1  one-cycle FIFO write strobe
fifo_full  in  1  FIFO full
seq_busy  out  1  high in any state except IDLE
timeout_err  out  1  sticky timeout flag
drop_count  out  CNT_W  results dropped on full, saturating

Behaviour:
- Reset (res=1 at a clk edge): state IDLE. adc_start=0, fifo_wr=0, fifo_data=0, seq_busy=0, timeout_err=0, drop_count=0, accumulator and counters cleared. Reset overrides any state, including mid-conversion; no write is issued.
- States: IDLE, START, WAIT_VALID, EMIT, INTERVAL.
- IDLE -> START when cfg_enable=1 and (cfg_continuous=1 or trigger=1).
  - On this transition: latch N = min(cfg_avg_log2, AVG_MAX_LOG2), clear accumulator and sample counter.
  - A trigger in any other state is ignored.
- START: adc_start=1 for exactly one cycle, timeout counter cleared, next state WAIT_VALID.
- WAIT_VALID: timeout counter increments each cycle.
  - On adc_valid: accumulator += adc_value (zero-extended), sample counter++.
    - If counter reaches 2^N -> EMIT.
    - Else if cfg_enable=0 -> IDLE, partial sum discarded.
    - Else -> START on the next cycle; no interval between samples of one average.
  - adc_valid and timeout expiring in the same cycle: the sample wins.
  - Timeout (counter reaches TIMEOUT_CYCLES with no adc_valid): timeout_err<=1, partial sum discarded, -> IDLE.
- EMIT, one cycle: result = accumulator >> N (truncating).
  - fifo_full=0: fifo_data<=result, fifo_wr=1 in the following cycle, one cycle wide.
  - fifo_full=1: no write; drop_count++ saturating at 2^CNT_W-1.
  - Next state: INTERVAL if cfg_continuous=1 and cfg_enable=1, else IDLE.
- INTERVAL: counts cfg_interval cycles, then -> IDLE, which immediately re-evaluates and re-enters START.
  - cfg_interval=0 exits after one cycle.
  - cfg_enable=0 in INTERVAL -> IDLE immediately.
- Latency, continuous mode, N=0, interval 0: adc_start to adc_start = ADC conversion time + 4 cycles (START, WAIT_VALID capture, EMIT, INTERVAL).
- clear_err: clears timeout_err and drop_count next cycle. If it coincides with a new timeout or drop, the set/increment wins (timeout_err=1, drop_count=1).
- fifo_data holds the last written result until the next write.
- cfg_avg_log2 changes take effect only at the next IDLE -> START.

Test Plan:
- Single-shot, N=0: cfg_enable=1, cfg_continuous=0, trigger pulse; ADC returns 0xA5 five cycles after adc_start -> exactly one adc_start, one fifo_wr with fifo_data=0xA5, back to IDLE, seq_busy low.
- Averaging, N=2: samples 0x10, 0x11, 0x12, 0x14 -> four adc_start pulses, one fifo_wr, fifo_data=0x11 (0x47>>2). Samples 0xFF x4 -> 0xFF with no overflow.
- Continuous with cfg_interval=10: count cycles from each fifo_wr to the next adc_start (must be 12). Deassert cfg_enable during INTERVAL -> no further adc_start.
- FIFO full: hold fifo_full=1 over 3 results -> no fifo_wr, drop_count=3. Then clear_err -> 0. Also check saturation with CNT_W forced to 2: 5 drops -> 3.
- Timeout, TIMEOUT_CYCLES=16: never assert adc_valid -> timeout_err=1 after 16 cycles, IDLE, no fifo_wr. A later trigger still converts normally.
- Reset mid-operation: assert res in WAIT_VALID with N=3 after 2 samples -> next cycle all outputs 0, state IDLE. The following trigger accumulates a fresh 8 samples.
